// File: rtl/sa_pkg.sv
// Shared systolic-array package: phase codes seen on the array control bus
// and a helper for sizing the phase-length countdown.
// Used by sa_tile_sequencer, the array top and the testbenches.
package sa_pkg;

    // Phase code driven to the array top
    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_WARMUP = 2'd1,
        PH_STEADY = 2'd2,
        PH_DRAIN  = 2'd3
    } phase_e;

    localparam int unsigned PERF_CNT_WIDTH = 16;

    // Width needed to hold the longest phase, k_len_max + NUM_ROW + NUM_COL - 2
    function automatic int unsigned phase_cnt_width(input int unsigned addr_w,
                                                    input int unsigned n_row,
                                                    input int unsigned n_col);
        int unsigned max_len;
        max_len = (32'd1 << addr_w) - 32'd1 + n_row + n_col - 32'd2;
        return (max_len < 32'd2) ? 32'd1 : $clog2(max_len + 32'd1);
    endfunction

endpackage

// File: rtl/sa_phase_counter.sv
// Phase-length countdown: loads a value, decrements toward zero, flags zero.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   i_load          load i_load_val (wins over decrement)
//   i_load_val      value to load (phase length minus one)
//   i_dec           decrement by one, stops at zero
//   o_zero_c        combinational flag, counter equals zero
module sa_phase_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero_c
);

    logic [WIDTH-1:0] cnt_q;

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= i_load_val;
        end else if (i_dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign o_zero_c = (cnt_q == '0);

endmodule

// File: rtl/sa_tile_sequencer.sv
// Tile sequencer for a systolic array: runs IDLE -> WARMUP -> STEADY -> DRAIN
// for one tile per accepted start and publishes the SRAM read windows.
// Optional feature: define SA_SEQ_PERF_CNT_EN to add o_cycle_cnt, the busy
// cycle count of the last completed tile (saturating).
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   i_start                  tile request, honoured when idle or on the final DRAIN cycle
//   i_k_len                  operand vectors per tile (0 is rejected)
//   i_top/left/down_base     first SRAM address of each buffer
//   o_busy                   high from accept until return to IDLE
//   o_done                   one-cycle pulse after DRAIN completes
//   o_err                    one-cycle pulse when a start is rejected
//   o_ctrl_state             phase code (sa_pkg::phase_e)
//   o_*_sram_rd_start/end_addr  read windows, held until the next accept
//   o_cycle_cnt              (SA_SEQ_PERF_CNT_EN only) busy cycles of last tile
module sa_tile_sequencer
    import sa_pkg::*;
#(
    parameter int unsigned NUM_ROW              = 4,
    parameter int unsigned NUM_COL              = 4,
    parameter int unsigned LOG2_SRAM_BANK_DEPTH = 5,
    parameter int unsigned CTRL_WIDTH           = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_k_len,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_base,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_base,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_down_base,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_err,
    output logic [CTRL_WIDTH-1:0]           o_ctrl_state,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_end_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_end_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_sram_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_sram_rd_end_addr
`ifdef SA_SEQ_PERF_CNT_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0]       o_cycle_cnt
`endif
);

    localparam int unsigned AW = LOG2_SRAM_BANK_DEPTH;
    localparam int unsigned CW = phase_cnt_width(LOG2_SRAM_BANK_DEPTH, NUM_ROW, NUM_COL);

    phase_e          state_q;
    phase_e          state_d;
    logic [AW-1:0]   k_len_q;
    logic            cnt_load_c;
    logic [CW-1:0]   cnt_load_val_c;
    logic            cnt_dec_c;
    logic            cnt_zero_c;
    logic            last_c;
    logic            start_window_c;
    logic            accept_c;
    logic            reject_c;
    logic [CW-1:0]   steady_len_m1_c;

    // Final DRAIN cycle doubles as a start window so tiles can run back-to-back
    assign last_c         = (state_q == PH_DRAIN) && cnt_zero_c;
    assign start_window_c = (state_q == PH_IDLE) || last_c;
    assign accept_c       = start_window_c && i_start && (i_k_len != '0);
    assign reject_c       = start_window_c && i_start && (i_k_len == '0);

    // STEADY lasts k_len + NUM_ROW + NUM_COL - 2 cycles; counter holds length - 1
    assign steady_len_m1_c = CW'(k_len_q) + CW'(NUM_ROW + NUM_COL - 32'd3);

    sa_phase_counter #(
        .WIDTH (CW)
    ) u_phase_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (cnt_load_c),
        .i_load_val (cnt_load_val_c),
        .i_dec      (cnt_dec_c),
        .o_zero_c   (cnt_zero_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and phase-counter control
    always_comb begin
        state_d        = state_q;
        cnt_load_c     = 1'b0;
        cnt_load_val_c = '0;
        cnt_dec_c      = 1'b0;
        case (state_q)
            PH_IDLE: begin
                if (accept_c) begin
                    state_d        = PH_WARMUP;
                    cnt_load_c     = 1'b1;
                    cnt_load_val_c = CW'(NUM_COL - 32'd1);
                end
            end
            PH_WARMUP: begin
                if (cnt_zero_c) begin
                    state_d        = PH_STEADY;
                    cnt_load_c     = 1'b1;
                    cnt_load_val_c = steady_len_m1_c;
                end else begin
                    cnt_dec_c = 1'b1;
                end
            end
            PH_STEADY: begin
                if (cnt_zero_c) begin
                    state_d        = PH_DRAIN;
                    cnt_load_c     = 1'b1;
                    cnt_load_val_c = CW'(NUM_ROW - 32'd1);
                end else begin
                    cnt_dec_c = 1'b1;
                end
            end
            PH_DRAIN: begin
                if (cnt_zero_c) begin
                    if (accept_c) begin
                        state_d        = PH_WARMUP;
                        cnt_load_c     = 1'b1;
                        cnt_load_val_c = CW'(NUM_COL - 32'd1);
                    end else begin
                        state_d = PH_IDLE;
                    end
                end else begin
                    cnt_dec_c = 1'b1;
                end
            end
            default: begin
                state_d = PH_IDLE;
            end
        endcase
    end

    assign o_ctrl_state = CTRL_WIDTH'(state_q);

    // Status pulses, latched tile length and read windows
    always_ff @(posedge clk) begin
        if (rst) begin
            o_busy                    <= 1'b0;
            o_done                    <= 1'b0;
            o_err                     <= 1'b0;
            k_len_q                   <= '0;
            o_top_sram_rd_start_addr  <= '0;
            o_top_sram_rd_end_addr    <= '0;
            o_left_sram_rd_start_addr <= '0;
            o_left_sram_rd_end_addr   <= '0;
            o_down_sram_rd_start_addr <= '0;
            o_down_sram_rd_end_addr   <= '0;
        end else begin
            o_busy <= (state_d != PH_IDLE);
            o_done <= last_c;
            o_err  <= reject_c;
            if (accept_c) begin
                k_len_q                   <= i_k_len;
                o_top_sram_rd_start_addr  <= i_top_base;
                o_top_sram_rd_end_addr    <= AW'(i_top_base + i_k_len - AW'(1));
                o_left_sram_rd_start_addr <= i_left_base;
                o_left_sram_rd_end_addr   <= AW'(i_left_base + i_k_len - AW'(1));
                o_down_sram_rd_start_addr <= i_down_base;
                o_down_sram_rd_end_addr   <= AW'(i_down_base + i_k_len - AW'(1));
            end
        end
    end

`ifdef SA_SEQ_PERF_CNT_EN
    logic [PERF_CNT_WIDTH-1:0] tile_cyc_q;
    logic [PERF_CNT_WIDTH-1:0] tile_cyc_inc_c;

    assign tile_cyc_inc_c = (tile_cyc_q == '1) ? tile_cyc_q
                                               : tile_cyc_q + PERF_CNT_WIDTH'(1);

    // Busy-cycle counter; the final DRAIN cycle is included via the increment
    always_ff @(posedge clk) begin
        if (rst) begin
            tile_cyc_q  <= '0;
            o_cycle_cnt <= '0;
        end else begin
            if (accept_c) begin
                tile_cyc_q <= '0;
            end else if (state_q != PH_IDLE) begin
                tile_cyc_q <= tile_cyc_inc_c;
            end
            if (last_c) begin
                o_cycle_cnt <= tile_cyc_inc_c;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Self-checking bench for sa_tile_sequencer: directed scenarios with literal
// expectations plus randomized traffic against a timeline-based model.
module tb_sa_tile_sequencer;
    localparam int unsigned NR = 4;
    localparam int unsigned NC = 4;
    localparam int unsigned AW = 5;
    localparam int unsigned CWD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [AW-1:0] i_k_len = '0;
    logic [AW-1:0] i_top_base = '0;
    logic [AW-1:0] i_left_base = '0;
    logic [AW-1:0] i_down_base = '0;
    logic          o_busy, o_done, o_err;
    logic [CWD-1:0] o_ctrl_state;
    logic [AW-1:0] o_ts, o_te, o_ls, o_le, o_ds, o_de;
`ifdef SA_SEQ_PERF_CNT_EN
    logic [15:0]   o_cycle_cnt;
`endif

    int checks = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    sa_tile_sequencer #(
        .NUM_ROW(NR), .NUM_COL(NC), .LOG2_SRAM_BANK_DEPTH(AW), .CTRL_WIDTH(CWD)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_k_len(i_k_len),
        .i_top_base(i_top_base), .i_left_base(i_left_base), .i_down_base(i_down_base),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_ctrl_state(o_ctrl_state),
        .o_top_sram_rd_start_addr(o_ts), .o_top_sram_rd_end_addr(o_te),
        .o_left_sram_rd_start_addr(o_ls), .o_left_sram_rd_end_addr(o_le),
        .o_down_sram_rd_start_addr(o_ds), .o_down_sram_rd_end_addr(o_de)
`ifdef SA_SEQ_PERF_CNT_EN
        , .o_cycle_cnt(o_cycle_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: tile timeline ----------------
    // m_el counts busy cycles of the current tile (1..total); phase follows from it.
    logic          m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
    int            m_el = 0;
    logic [AW-1:0] m_k = '0;
    logic [AW-1:0] m_tb = '0, m_lb = '0, m_db = '0;
    int            m_cyc = 0;
    int            m_total;
    logic          m_last, m_free;

    assign m_total = int'(NC) + (int'(m_k) + int'(NR) + int'(NC) - 2) + int'(NR);
    assign m_last  = m_busy && (m_el == m_total);
    assign m_free  = !m_busy || m_last;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_el <= 0;
            m_k <= '0; m_tb <= '0; m_lb <= '0; m_db <= '0; m_cyc <= 0;
        end else begin
            m_done <= m_last;
            m_err  <= m_free && i_start && (i_k_len == '0);
            if (m_last) m_cyc <= (m_total > 65535) ? 65535 : m_total;
            if (m_free && i_start && (i_k_len != '0)) begin
                m_busy <= 1'b1; m_el <= 1; m_k <= i_k_len;
                m_tb <= i_top_base; m_lb <= i_left_base; m_db <= i_down_base;
            end else if (m_last) begin
                m_busy <= 1'b0; m_el <= 0;
            end else if (m_busy) begin
                m_el <= m_el + 1;
            end
        end
    end

    function automatic int exp_phase();
        if (!m_busy) return 0;
        if (m_el <= int'(NC)) return 1;
        if (m_el <= int'(NC) + int'(m_k) + int'(NR) + int'(NC) - 2) return 2;
        return 3;
    endfunction

    function automatic logic [AW-1:0] win_end(input logic [AW-1:0] b, input logic [AW-1:0] k);
        int unsigned e;
        e = (int'(b) + int'(k) + (1 << AW) - 1) % (1 << AW);
        return AW'(e);
    endfunction

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("state", 32'(o_ctrl_state), 32'(exp_phase()));
            chk("busy", 32'(o_busy), 32'(m_busy));
            chk("done", 32'(o_done), 32'(m_done));
            chk("err", 32'(o_err), 32'(m_err));
            chk("top_start", 32'(o_ts), 32'(m_tb));
            chk("top_end", 32'(o_te), 32'(m_busy || m_k != 0 ? win_end(m_tb, m_k) : '0));
            chk("left_start", 32'(o_ls), 32'(m_lb));
            chk("left_end", 32'(o_le), 32'(m_busy || m_k != 0 ? win_end(m_lb, m_k) : '0));
            chk("down_start", 32'(o_ds), 32'(m_db));
            chk("down_end", 32'(o_de), 32'(m_busy || m_k != 0 ? win_end(m_db, m_k) : '0));
`ifdef SA_SEQ_PERF_CNT_EN
            chk("cycle_cnt", 32'(o_cycle_cnt), 32'(m_cyc));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic s, input logic [AW-1:0] k, input logic [AW-1:0] t,
                         input logic [AW-1:0] l, input logic [AW-1:0] d);
        i_start = s; i_k_len = k; i_top_base = t; i_left_base = l; i_down_base = d;
    endtask

    // Waits for o_done within budget cycles; returns cycles taken or -1
    task automatic wait_done(input int budget, input string name, output int cyc);
        cyc = -1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (o_done) begin
                cyc = n;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL %s timeout actual=no_done required=done_within_%0d", name, budget);
    endtask

    initial begin
        int busy_cnt;
        int cyc;
        int exp_st;
        logic seen_done;

        // Reset, with a start request that must be ignored
        drive(1'b1, AW'(4), AW'(9), AW'(9), AW'(9));
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_state", 32'(o_ctrl_state), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_addr", 32'(o_te), 32'd0);
        drive(1'b0, '0, '0, '0, '0);
        rst = 1'b0;
        @(negedge clk);

        // Canonical tile: k_len=4, accept edge is cycle 0
        drive(1'b1, AW'(4), AW'(3), AW'(7), AW'(11));
        @(negedge clk);
        i_start = 1'b0;
        busy_cnt = 0;
        for (int n = 1; n <= 19; n++) begin
            exp_st = (n <= 4) ? 1 : (n <= 14) ? 2 : (n <= 18) ? 3 : 0;
            chk("canon_state", 32'(o_ctrl_state), 32'(exp_st));
            if (o_busy) busy_cnt++;
            if (n == 1) begin
                chk("canon_top_start", 32'(o_ts), 32'd3);
                chk("canon_down_end", 32'(o_de), 32'd14);
            end
            if (n == 18) chk("canon_done_early", 32'(o_done), 32'd0);
            if (n == 19) chk("canon_done", 32'(o_done), 32'd1);
            if (n < 19) @(negedge clk);
        end
        chk("canon_busy_cycles", 32'(busy_cnt), 32'd18);
`ifdef SA_SEQ_PERF_CNT_EN
        chk("canon_cycle_cnt", 32'(o_cycle_cnt), 32'd18);
`endif
        @(negedge clk);

        // k_len=0 is rejected with a single err pulse
        drive(1'b1, AW'(0), AW'(1), AW'(2), AW'(3));
        @(negedge clk);
        i_start = 1'b0;
        chk("zero_err", 32'(o_err), 32'd1);
        chk("zero_state", 32'(o_ctrl_state), 32'd0);
        chk("zero_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        chk("zero_err_pulse", 32'(o_err), 32'd0);

        // Wrap-around window
        drive(1'b1, AW'(4), AW'(30), AW'(0), AW'(31));
        @(negedge clk);
        i_start = 1'b0;
        chk("wrap_top_start", 32'(o_ts), 32'd30);
        chk("wrap_top_end", 32'(o_te), 32'd1);
        chk("wrap_down_end", 32'(o_de), 32'd2);
        wait_done(40, "wrap_done", cyc);
        @(negedge clk);

        // Reset during STEADY aborts with no done; next tile runs normally
        drive(1'b1, AW'(4), AW'(5), AW'(6), AW'(7));
        @(negedge clk);
        i_start = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_in_steady", 32'(o_ctrl_state), 32'd2);
        rst = 1'b1;
        i_start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        i_start = 1'b0;
        chk("abort_state", 32'(o_ctrl_state), 32'd0);
        chk("abort_addr", 32'(o_ts), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        seen_done = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (o_done) seen_done = 1'b1;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        drive(1'b1, AW'(2), AW'(8), AW'(9), AW'(10));
        @(negedge clk);
        i_start = 1'b0;
        wait_done(40, "after_abort_done", cyc);
        chk("after_abort_latency", 32'(cyc), 32'd16);

        // Start held across done: back-to-back, busy-time starts ignored
        @(negedge clk);
        drive(1'b1, AW'(1), AW'(12), AW'(13), AW'(14));
        @(negedge clk);
        i_top_base = AW'(20);
        wait_done(40, "b2b_first_done", cyc);
        chk("b2b_first_latency", 32'(cyc), 32'd15);
        chk("b2b_state", 32'(o_ctrl_state), 32'd1);
        chk("b2b_busy", 32'(o_busy), 32'd1);
        chk("b2b_top_start", 32'(o_ts), 32'd20);
        i_start = 1'b0;
        wait_done(40, "b2b_second_done", cyc);
        chk("b2b_second_latency", 32'(cyc), 32'd15);

        // Randomized traffic, model-checked every cycle
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            i_start = ($urandom_range(0, 3) == 0);
            i_k_len = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom);
            i_top_base = AW'($urandom);
            i_left_base = AW'($urandom);
            i_down_base = AW'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        i_start = 1'b0;
        repeat (50) @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
